wishbus_rr_arbiter: RTL and testbench
=====================================

Name: wishbus_rr_arbiter

Overview:
- Round-robin arbiter sharing one wishbus memory device (RAM bridge or SDRAM port) among N burst masters (mem_burst_if-style requesters).
- Replaces fixed-priority sharing with fair, registered grants, a per-grant watchdog and a single-owner datapath mux.
- Sits between the requesters and the device-side bus; the device sees exactly one master at a time.

Parameters:
- N, 4, number of requesters (2..8).
- AW, 32, address width.
- DW, 16, data width.
- TIMEOUT, 255, max cycles a grant may stay idle (no strobe) before forced revoke; 0 disables watchdog.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  N  per-requester bus request, level; held until done with bus.
- gnt_o  out  N  one-hot grant, registered.
- u_stb_i  in  N  per-requester strobe.
- u_we_i  in  N  per-requester read(1)/write(0) select.
- u_addr_i  in  N*AW  packed addresses, requester k at [k*AW +: AW].
- u_dat_i  in  N*DW  packed write data.
- u_stb_o  out  N  strobe-accepted, routed to granted requester only.
- u_cyc_o  out  N  device busy, routed to granted requester only.
- u_dat_o  out  DW  read data, broadcast.
- m_stb_o  out  1  device strobe.
- m_we_o  out  1  device read(1)/write(0).
- m_addr_o  out  AW  device address.
- m_dat_o  out  DW  device write data.
- m_stb_i  in  1  device strobe-accepted.
- m_cyc_i  in  1  device busy.
- m_dat_i  in  DW  device read data.
- owner_o  out  $clog2(N)  index of current owner; valid while busy_o.
- busy_o  out  1  a grant is active.
- revoke_o  out  1  one-cycle pulse on watchdog revoke.

Behaviour:
- Reset, async: state IDLE; gnt_o=0; busy_o=0; revoke_o=0; owner_o=0; rr pointer=0; watchdog=0.
- Reset values of combinational outputs: m_stb_o=0, m_we_o=1, m_addr_o=0, m_dat_o=0, u_stb_o=0, u_cyc_o=0.
- FSM states:
  - IDLE: if any req_i and !m_cyc_i, select the first set req starting at pointer, wrapping N-1 -> 0. Next cycle: gnt_o one-hot, owner_o=k, busy_o=1, state GRANT. Grant latency is 1 cycle from req.
  - GRANT: requester k's stb/we/addr/dat forwarded combinationally to m_*. m_stb_i and m_cyc_i go to u_stb_o[k] and u_cyc_o[k]; other bits stay 0. u_stb_i[k]=1 resets the watchdog and moves to BUSY.
  - BUSY: stays while m_cyc_i or u_stb_i[k]. When both are low: if req_i[k] still set, return to GRANT (burst continues, same owner); else go to RELEASE.
  - RELEASE: gnt_o=0, busy_o=0, pointer=(k+1) mod N, state IDLE. At least one dead cycle between owners.
- Non-owner outputs/inputs: when not busy, or for non-owners, m_stb_o=0, m_we_o=1, m_addr_o=0, m_dat_o=0. Non-owner u_stb_i is ignored.
- u_dat_o: always equals m_dat_i.
- Watchdog: counts GRANT cycles without u_stb_i[k]. At TIMEOUT it pulses revoke_o and goes to RELEASE, even if req_i[k] is still set. Revoke is never taken in BUSY; an in-flight device cycle always completes.
- req_i[k] dropped while in GRANT: go to RELEASE next cycle.
- Simultaneous requests: pointer order decides. A requester re-raising req in RELEASE has lowest priority next round.
- Requester at the pointer with req low: it is skipped; no idle cycle is spent on it.
- m_cyc_i high in IDLE (device still finishing): grant is withheld until it goes low.
- Reset mid-transaction: everything returns to IDLE at once; m_stb_o drops asynchronously.

Test Plan:
- Single requester: req_i=0001 -> gnt_o=0001 one cycle later; write addr 0x10, data 0xBEEF reaches m_* unchanged; drop req -> gnt_o=0 next cycle, pointer=1.
- Fairness: req_i=1111 held, each master does one transfer then drops/re-raises -> grant order 0,1,2,3,0 with one dead cycle between owners.
- Burst hold: master 2 keeps req and does 4 strobes at addr 0x100..0x106 -> gnt_o stays 0100 throughout; no other grant even with req_i[0]=1.
- Watchdog: TIMEOUT=8, master 1 granted with no strobe -> revoke_o pulses on cycle 8 after grant, gnt_o=0, master 2 granted next.
- Read routing: master 3 reads, m_dat_i=0x1234 -> u_dat_o=0x1234; u_stb_o and u_cyc_o asserted only on bit 3.
- Async reset asserted in BUSY with m_stb_o=1 -> m_stb_o=0 and gnt_o=0 immediately, without waiting for a clock edge; IDLE after deassert.

Source files
------------

// File: rtl/wishbus_rr_arbiter_if.sv
// Bus bundle between the N burst requesters, the round-robin arbiter and the shared wishbus device.
// The arbiter uses the master modport; the requester/device environment uses slave.
interface wishbus_rr_arbiter_if #(
    parameter int N  = 4,
    parameter int AW = 32,
    parameter int DW = 16
);
    logic [N-1:0]    req_i;
    logic [N-1:0]    gnt_o;
    logic [N-1:0]    u_stb_i;
    logic [N-1:0]    u_we_i;
    logic [N*AW-1:0] u_addr_i;
    logic [N*DW-1:0] u_dat_i;
    logic [N-1:0]    u_stb_o;
    logic [N-1:0]    u_cyc_o;
    logic [DW-1:0]   u_dat_o;
    logic            m_stb_o;
    logic            m_we_o;
    logic [AW-1:0]   m_addr_o;
    logic [DW-1:0]   m_dat_o;
    logic            m_stb_i;
    logic            m_cyc_i;
    logic [DW-1:0]   m_dat_i;

    modport master (
        input  req_i, u_stb_i, u_we_i, u_addr_i, u_dat_i, m_stb_i, m_cyc_i, m_dat_i,
        output gnt_o, u_stb_o, u_cyc_o, u_dat_o, m_stb_o, m_we_o, m_addr_o, m_dat_o
    );

    modport slave (
        output req_i, u_stb_i, u_we_i, u_addr_i, u_dat_i, m_stb_i, m_cyc_i, m_dat_i,
        input  gnt_o, u_stb_o, u_cyc_o, u_dat_o, m_stb_o, m_we_o, m_addr_o, m_dat_o
    );
endinterface

// File: rtl/wishbus_rr_arbiter.sv
// Round-robin arbiter giving N burst masters exclusive, registered access to one wishbus device,
// with an idle-grant watchdog and a single-owner datapath mux.
module wishbus_rr_arbiter #(
    parameter int N       = 4,
    parameter int AW      = 32,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wishbus_rr_arbiter_if.master bus,
    output logic [$clog2(N)-1:0] owner_o,
    output logic                 busy_o,
    output logic                 revoke_o
);
    localparam int OW    = $clog2(N);
    localparam int WDW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WDLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [OW:0] NV = N[OW:0];

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RELEASE} state_t;

    state_t          r_state, w_state_nx;
    logic [N-1:0]    r_gnt;
    logic [OW-1:0]   r_owner, r_ptr;
    logic            r_busy, r_revoke;
    logic [WDW-1:0]  r_wdog;

    logic [2*N-1:0]  w_req2;
    logic [N-1:0]    w_rot;
    logic [OW-1:0]   w_off, w_pick, w_ptr_nx;
    logic [OW:0]     w_sum;
    logic            w_any;
    logic            w_take, w_rel, w_revoke, w_wd_clr, w_wd_inc, w_wd_hit;
    logic            w_own_req, w_own_stb;

    // Rotate requests so the pointer sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        w_req2 = {bus.req_i, bus.req_i};
        w_rot  = w_req2[r_ptr +: N];
        w_any  = 1'b0;
        w_off  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_any = 1'b1;
                w_off = OW'(i);
            end
        end
        w_sum    = {1'b0, r_ptr} + {1'b0, w_off};
        w_pick   = (w_sum >= NV) ? OW'(w_sum - NV) : OW'(w_sum);
        w_ptr_nx = (r_owner == OW'(N - 1)) ? '0 : r_owner + 1'b1;
    end

    always_comb begin
        w_state_nx = r_state;
        w_take     = 1'b0;
        w_rel      = 1'b0;
        w_revoke   = 1'b0;
        w_wd_clr   = 1'b0;
        w_wd_inc   = 1'b0;
        w_own_req  = |(bus.req_i & r_gnt);
        w_own_stb  = |(bus.u_stb_i & r_gnt);
        w_wd_hit   = (TIMEOUT != 0) && (r_wdog == WDW'(WDLIM));
        case (r_state)
            S_IDLE: begin
                if (w_any && !bus.m_cyc_i) begin
                    w_take     = 1'b1;
                    w_wd_clr   = 1'b1;
                    w_state_nx = S_GRANT;
                end
            end
            S_GRANT: begin
                // A strobe wins over a simultaneous req drop so the device cycle is never cut.
                if (w_own_stb) begin
                    w_wd_clr   = 1'b1;
                    w_state_nx = S_BUSY;
                end else if (!w_own_req) begin
                    w_rel      = 1'b1;
                    w_state_nx = S_RELEASE;
                end else if (w_wd_hit) begin
                    w_rel      = 1'b1;
                    w_revoke   = 1'b1;
                    w_state_nx = S_RELEASE;
                end else begin
                    w_wd_inc   = 1'b1;
                end
            end
            S_BUSY: begin
                if (!bus.m_cyc_i && !w_own_stb) begin
                    if (w_own_req) begin
                        w_wd_clr   = 1'b1;
                        w_state_nx = S_GRANT;
                    end else begin
                        w_rel      = 1'b1;
                        w_state_nx = S_RELEASE;
                    end
                end
            end
            S_RELEASE: w_state_nx = S_IDLE;
            default:   w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_ptr    <= '0;
            r_busy   <= 1'b0;
            r_revoke <= 1'b0;
            r_wdog   <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_revoke <= w_revoke;
            if (w_take) begin
                r_gnt   <= N'(1) << w_pick;
                r_owner <= w_pick;
                r_busy  <= 1'b1;
            end
            if (w_rel) begin
                r_gnt  <= '0;
                r_busy <= 1'b0;
                r_ptr  <= w_ptr_nx;
            end
            if (w_wd_clr)      r_wdog <= '0;
            else if (w_wd_inc) r_wdog <= r_wdog + 1'b1;
        end
    end

    // Grant bits clear asynchronously on reset, so the mux closes without a clock edge.
    always_comb begin
        bus.m_stb_o  = 1'b0;
        bus.m_we_o   = 1'b1;
        bus.m_addr_o = '0;
        bus.m_dat_o  = '0;
        bus.u_stb_o  = '0;
        bus.u_cyc_o  = '0;
        for (int k = 0; k < N; k++) begin
            if (r_gnt[k]) begin
                bus.m_stb_o  = bus.u_stb_i[k];
                bus.m_we_o   = bus.u_we_i[k];
                bus.m_addr_o = bus.u_addr_i[k*AW +: AW];
                bus.m_dat_o  = bus.u_dat_i[k*DW +: DW];
                bus.u_stb_o[k] = bus.m_stb_i;
                bus.u_cyc_o[k] = bus.m_cyc_i;
            end
        end
    end

    assign bus.gnt_o   = r_gnt;
    assign bus.u_dat_o = bus.m_dat_i;
    assign owner_o     = r_owner;
    assign busy_o      = r_busy;
    assign revoke_o    = r_revoke;
endmodule

// File: tb/tb_wishbus_rr_arbiter.sv
// Directed bench for wishbus_rr_arbiter: grant latency, fairness, bursts, watchdog, routing, reset.
module tb_wishbus_rr_arbiter;
    localparam int N = 4, AW = 32, DW = 16;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [1:0] owner_o;
    logic       busy_o, revoke_o;
    int         checks = 0, failures = 0;

    wishbus_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus();

    wishbus_rr_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
        .owner_o(owner_o), .busy_o(busy_o), .revoke_o(revoke_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic cyc();
        @(posedge clk_i);
        #2;
    endtask

    task automatic clr_inputs();
        bus.req_i = '0; bus.u_stb_i = '0; bus.u_we_i = '0; bus.u_addr_i = '0; bus.u_dat_i = '0;
        bus.m_stb_i = 1'b0; bus.m_cyc_i = 1'b0; bus.m_dat_i = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        rst_i = 1'b1;
        cyc(); cyc();
        rst_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        clr_inputs();
        bus.m_dat_i = 16'h5A5A;
        rst_i = 1'b1;
        #3;
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b exp 0000", bus.gnt_o); end
        checks++; if ({busy_o, revoke_o} !== 2'b00) begin failures++; $display("FAIL reset_busy_revoke: got %b exp 00", {busy_o, revoke_o}); end
        checks++; if (owner_o !== 2'd0) begin failures++; $display("FAIL reset_owner: got %0d exp 0", owner_o); end
        checks++; if ({bus.m_stb_o, bus.m_we_o} !== 2'b01) begin failures++; $display("FAIL reset_m_stb_we: got %b exp 01", {bus.m_stb_o, bus.m_we_o}); end
        checks++; if ({bus.m_addr_o, bus.m_dat_o} !== 48'h0) begin failures++; $display("FAIL reset_m_addr_dat: got %h exp 0", {bus.m_addr_o, bus.m_dat_o}); end
        checks++; if ({bus.u_stb_o, bus.u_cyc_o} !== 8'h00) begin failures++; $display("FAIL reset_u_stb_cyc: got %b exp 0", {bus.u_stb_o, bus.u_cyc_o}); end
        checks++; if (bus.u_dat_o !== 16'h5A5A) begin failures++; $display("FAIL reset_u_dat: got %h exp 5a5a", bus.u_dat_o); end
        cyc();
        rst_i = 1'b0;
        bus.m_dat_i = '0;
        cyc();
    endtask

    task automatic test_single();
        bus.req_i = 4'b0001;
        cyc();
        checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL single_gnt: got %b exp 0001", bus.gnt_o); end
        checks++; if ({busy_o, owner_o} !== 3'b100) begin failures++; $display("FAIL single_busy_owner: got %b exp 100", {busy_o, owner_o}); end
        bus.u_stb_i = 4'b0001; bus.u_we_i = 4'b0000;
        bus.u_addr_i[0 +: AW] = 32'h10; bus.u_dat_i[0 +: DW] = 16'hBEEF;
        bus.m_stb_i = 1'b1; bus.m_cyc_i = 1'b1;
        #1;
        checks++; if ({bus.m_stb_o, bus.m_we_o} !== 2'b10) begin failures++; $display("FAIL single_m_stb_we: got %b exp 10", {bus.m_stb_o, bus.m_we_o}); end
        checks++; if (bus.m_addr_o !== 32'h10) begin failures++; $display("FAIL single_m_addr: got %h exp 10", bus.m_addr_o); end
        checks++; if (bus.m_dat_o !== 16'hBEEF) begin failures++; $display("FAIL single_m_dat: got %h exp beef", bus.m_dat_o); end
        checks++; if ({bus.u_stb_o, bus.u_cyc_o} !== 8'b0001_0001) begin failures++; $display("FAIL single_u_stb_cyc: got %b exp 00010001", {bus.u_stb_o, bus.u_cyc_o}); end
        cyc();
        bus.u_stb_i = '0; bus.m_stb_i = 1'b0; bus.m_cyc_i = 1'b0; bus.req_i = '0;
        cyc();
        checks++; if ({bus.gnt_o, busy_o} !== 5'b0) begin failures++; $display("FAIL single_release: got %b exp 00000", {bus.gnt_o, busy_o}); end
        // Pointer now at 1: with 0 and 1 both requesting, 1 must win.
        bus.req_i = 4'b0011;
        cyc(); cyc();
        checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL single_ptr_next: got %b exp 0010", bus.gnt_o); end
        bus.req_i = '0;
        cyc();
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL grant_req_drop: got %b exp 0000", bus.gnt_o); end
        cyc();
    endtask

    task automatic test_fairness();
        int order[5] = '{0, 1, 2, 3, 0};
        do_reset();
        bus.req_i = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int  dead = 0;
            bit  got  = 1'b0;
            for (int t = 0; t < 8 && !got; t++) begin
                cyc();
                if (bus.gnt_o !== 4'b0000) got = 1'b1; else dead++;
            end
            checks++; if (!got || bus.gnt_o !== 4'(1 << order[n])) begin failures++; $display("FAIL fair_order[%0d]: got %b exp %b", n, bus.gnt_o, 4'(1 << order[n])); end
            if (n > 0) begin
                checks++; if (dead < 1) begin failures++; $display("FAIL fair_dead[%0d]: got %0d exp >=1", n, dead); end
            end
            bus.u_stb_i = 4'(1 << order[n]); bus.m_stb_i = 1'b1; bus.m_cyc_i = 1'b1;
            cyc();
            bus.u_stb_i = '0; bus.m_stb_i = 1'b0; bus.m_cyc_i = 1'b0;
            bus.req_i = bus.req_i & ~4'(1 << order[n]);
            cyc();
            bus.req_i = bus.req_i | 4'(1 << order[n]);
        end
        bus.req_i = '0;
    endtask

    task automatic test_burst();
        do_reset();
        bus.req_i = 4'b0100;
        cyc();
        checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL burst_gnt: got %b exp 0100", bus.gnt_o); end
        bus.req_i = 4'b0101;
        for (int s = 0; s < 4; s++) begin
            bus.u_stb_i = 4'b0100;
            bus.u_addr_i[2*AW +: AW] = 32'h100 + 32'(2 * s);
            #1;
            checks++; if (bus.m_addr_o !== 32'h100 + 32'(2 * s)) begin failures++; $display("FAIL burst_addr[%0d]: got %h exp %h", s, bus.m_addr_o, 32'h100 + 32'(2 * s)); end
            cyc();
            bus.u_stb_i = '0;
            cyc();
            checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL burst_hold[%0d]: got %b exp 0100", s, bus.gnt_o); end
        end
        bus.req_i = 4'b0001;
        cyc();
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL burst_release: got %b exp 0000", bus.gnt_o); end
        cyc(); cyc();
        checks++; if ({bus.gnt_o, owner_o} !== 6'b0001_00) begin failures++; $display("FAIL burst_wrap: got %b exp 000100", {bus.gnt_o, owner_o}); end
        bus.req_i = '0;
        cyc(); cyc();
    endtask

    task automatic test_watchdog();
        do_reset();
        bus.req_i = 4'b0110;
        cyc();
        checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL wd_gnt: got %b exp 0010", bus.gnt_o); end
        for (int c = 1; c < 8; c++) begin
            cyc();
            checks++; if ({bus.gnt_o, revoke_o} !== 5'b0010_0) begin failures++; $display("FAIL wd_wait[%0d]: got %b exp 00100", c, {bus.gnt_o, revoke_o}); end
        end
        cyc();
        checks++; if ({bus.gnt_o, revoke_o} !== 5'b0000_1) begin failures++; $display("FAIL wd_revoke: got %b exp 00001", {bus.gnt_o, revoke_o}); end
        cyc();
        checks++; if (revoke_o !== 1'b0) begin failures++; $display("FAIL wd_pulse: got %b exp 0", revoke_o); end
        cyc();
        checks++; if (bus.gnt_o !== 4'b0100) begin failures++; $display("FAIL wd_next: got %b exp 0100", bus.gnt_o); end
        bus.req_i = '0;
        cyc(); cyc();
    endtask

    task automatic test_read();
        do_reset();
        bus.req_i = 4'b1000;
        cyc();
        checks++; if ({bus.gnt_o, owner_o} !== 6'b1000_11) begin failures++; $display("FAIL read_gnt: got %b exp 100011", {bus.gnt_o, owner_o}); end
        bus.u_stb_i = 4'b1001; bus.u_we_i = 4'b1001;
        bus.u_addr_i[3*AW +: AW] = 32'h40; bus.u_addr_i[0 +: AW] = 32'hAAAA;
        bus.m_stb_i = 1'b1; bus.m_cyc_i = 1'b1; bus.m_dat_i = 16'h1234;
        #1;
        checks++; if (bus.u_dat_o !== 16'h1234) begin failures++; $display("FAIL read_u_dat: got %h exp 1234", bus.u_dat_o); end
        checks++; if ({bus.u_stb_o, bus.u_cyc_o} !== 8'b1000_1000) begin failures++; $display("FAIL read_u_stb_cyc: got %b exp 10001000", {bus.u_stb_o, bus.u_cyc_o}); end
        checks++; if ({bus.m_we_o, bus.m_addr_o} !== {1'b1, 32'h40}) begin failures++; $display("FAIL read_m_we_addr: got %h exp 100000040", {bus.m_we_o, bus.m_addr_o}); end
        cyc();
        bus.u_stb_i = '0; bus.m_stb_i = 1'b0; bus.req_i = '0;
        cyc();
        checks++; if ({bus.gnt_o, bus.u_cyc_o} !== 8'b1000_1000) begin failures++; $display("FAIL read_cyc_hold: got %b exp 10001000", {bus.gnt_o, bus.u_cyc_o}); end
        bus.m_cyc_i = 1'b0;
        cyc();
        checks++; if (bus.gnt_o !== 4'b0000) begin failures++; $display("FAIL read_release: got %b exp 0000", bus.gnt_o); end
        cyc();
    endtask

    task automatic test_cyc_hold();
        do_reset();
        bus.m_cyc_i = 1'b1; bus.req_i = 4'b0010; bus.u_stb_i = 4'b1111;
        bus.u_addr_i = {4{32'hCAFE_0001}};
        for (int c = 0; c < 3; c++) begin
            cyc();
            checks++; if ({bus.gnt_o, bus.m_stb_o, bus.m_addr_o} !== 37'h0) begin failures++; $display("FAIL cyc_hold[%0d]: got %h exp 0", c, {bus.gnt_o, bus.m_stb_o, bus.m_addr_o}); end
        end
        bus.m_cyc_i = 1'b0; bus.u_stb_i = '0;
        cyc();
        checks++; if (bus.gnt_o !== 4'b0010) begin failures++; $display("FAIL cyc_hold_grant: got %b exp 0010", bus.gnt_o); end
        bus.req_i = '0;
        cyc(); cyc();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req_i = 4'b0010;
        cyc();
        bus.u_stb_i = 4'b0010; bus.m_stb_i = 1'b1; bus.m_cyc_i = 1'b1;
        cyc();
        checks++; if (bus.m_stb_o !== 1'b1) begin failures++; $display("FAIL arst_pre_stb: got %b exp 1", bus.m_stb_o); end
        #3 rst_i = 1'b1;
        #1;
        checks++; if ({bus.m_stb_o, bus.gnt_o, busy_o} !== 6'b0) begin failures++; $display("FAIL arst_immediate: got %b exp 000000", {bus.m_stb_o, bus.gnt_o, busy_o}); end
        clr_inputs();
        cyc();
        rst_i = 1'b0;
        cyc();
        checks++; if ({bus.gnt_o, busy_o} !== 5'b0) begin failures++; $display("FAIL arst_idle: got %b exp 00000", {bus.gnt_o, busy_o}); end
        bus.req_i = 4'b0001;
        cyc();
        checks++; if (bus.gnt_o !== 4'b0001) begin failures++; $display("FAIL arst_regrant: got %b exp 0001", bus.gnt_o); end
        bus.req_i = '0;
        cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_burst();
        test_watchdog();
        test_read();
        test_cyc_hold();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
